// File: rtl/cp0_multitimer_if.sv
// cp0_multitimer_if: MTC0/MFC0, exception/ERET and interrupt signals of the CP0 multitimer block
interface cp0_multitimer_if #(parameter int NUM_TIMERS = 1);
  logic [4:0] ra, wa;
  logic [2:0] rsel, wsel;
  logic write_enable;
  logic [31:0] wd, rd;
  logic [7:0] interrupt_info;
  logic exception_enable;
  logic [4:0] ecode;
  logic [31:0] pc, addr;
  logic bd, eret_enable;
  logic [31:0] epc;
  logic [5:0] ext_int;
  logic [NUM_TIMERS-1:0] timer_irq;
  modport master(output ra, wa, rsel, wsel, write_enable, wd, exception_enable, ecode, pc, addr, bd,
                 eret_enable, ext_int, input rd, interrupt_info, epc, timer_irq);
  modport slave(input ra, wa, rsel, wsel, write_enable, wd, exception_enable, ecode, pc, addr, bd,
                eret_enable, ext_int, output rd, interrupt_info, epc, timer_irq);
endinterface

// File: rtl/cp0_multitimer.sv
// cp0_multitimer: CP0 register file with prescaled Count, NUM_TIMERS Compare channels and sticky timer flags
module cp0_multitimer #(
  parameter int NUM_TIMERS = 1,
  parameter int COUNT_DIV = 2
) (
  input logic clk,
  input logic reset,
  cp0_multitimer_if.slave bus
);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, epc_q, epc_d;
  logic [31:0] compare_q [NUM_TIMERS];
  logic [31:0] compare_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] flag_q, flag_d, wr_cmp;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] im_q, im_d, ip;
  logic exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, ti, mtc0, wr_count, tick;
  logic [4:0] exccode_q, exccode_d;
  logic [1:0] ip_sw_q, ip_sw_d;
  logic [5:0] ext_q;
  logic [31:0] status, cause, rd_cmp;
  always_comb begin
    mtc0 = bus.write_enable & ~bus.exception_enable & ~bus.eret_enable;
    wr_count = mtc0 && bus.wa == 5'd9;
    tick = (COUNT_DIV == 1) || (&pre_q);
    pre_d = (wr_count || COUNT_DIV == 1) ? '0 : pre_q + PW'(1);
    count_d = wr_count ? bus.wd : count_q + 32'(tick);
    // a Compare write in the same cycle as a match leaves the flag clear
    for (int k = 0; k < NUM_TIMERS; k++) begin
      wr_cmp[k] = mtc0 && bus.wa == 5'd11 && bus.wsel == 3'(k);
      compare_d[k] = wr_cmp[k] ? bus.wd : compare_q[k];
      flag_d[k] = ~wr_cmp[k] & (flag_q[k] | (tick & ~wr_count & (count_d == compare_q[k])));
    end
    badvaddr_d = badvaddr_q;
    epc_d = epc_q;
    bd_d = bd_q;
    exccode_d = exccode_q;
    exl_d = exl_q;
    ie_d = ie_q;
    im_d = im_q;
    ip_sw_d = ip_sw_q;
    if (bus.exception_enable) begin
      exccode_d = bus.ecode;
      badvaddr_d = (bus.ecode == 5'd4 || bus.ecode == 5'd5) ? bus.addr : badvaddr_q;
      epc_d = exl_q ? epc_q : (bus.bd ? bus.pc - 32'd4 : bus.pc);
      bd_d = exl_q ? bd_q : bus.bd;
      exl_d = 1'b1;
    end else if (bus.eret_enable) begin
      exl_d = 1'b0;
    end else if (mtc0) begin
      im_d = bus.wa == 5'd12 ? bus.wd[15:8] : im_q;
      exl_d = bus.wa == 5'd12 ? bus.wd[1] : exl_q;
      ie_d = bus.wa == 5'd12 ? bus.wd[0] : ie_q;
      ip_sw_d = bus.wa == 5'd13 ? bus.wd[9:8] : ip_sw_q;
      epc_d = bus.wa == 5'd14 ? bus.wd : epc_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= '0;
      count_q <= '0;
      epc_q <= '0;
      compare_q <= '{default: '0};
      flag_q <= '0;
      pre_q <= '0;
      im_q <= '0;
      exl_q <= 1'b0;
      ie_q <= 1'b0;
      bd_q <= 1'b0;
      exccode_q <= '0;
      ip_sw_q <= '0;
      ext_q <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q <= count_d;
      epc_q <= epc_d;
      compare_q <= compare_d;
      flag_q <= flag_d;
      pre_q <= pre_d;
      im_q <= im_d;
      exl_q <= exl_d;
      ie_q <= ie_d;
      bd_q <= bd_d;
      exccode_q <= exccode_d;
      ip_sw_q <= ip_sw_d;
      ext_q <= bus.ext_int;
    end
  end
  always_comb begin
    ti = |flag_q;
    ip = {ext_q[5] | ti, ext_q[4:0], ip_sw_q};
    status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    cause = {bd_q, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};
    rd_cmp = '0;
    for (int k = 0; k < NUM_TIMERS; k++)
      rd_cmp = bus.rsel == 3'(k) ? compare_q[k] : rd_cmp;
    case (bus.ra)
      5'd8: bus.rd = badvaddr_q;
      5'd9: bus.rd = count_q;
      5'd11: bus.rd = rd_cmp;
      5'd12: bus.rd = status;
      5'd13: bus.rd = cause;
      5'd14: bus.rd = epc_q;
      default: bus.rd = '0;
    endcase
    bus.interrupt_info = ip & im_q & {8{ie_q & ~exl_q}};
    bus.epc = epc_q;
    bus.timer_irq = flag_q;
  end
endmodule

// File: tb/tb_cp0_multitimer.sv
// tb_cp0_multitimer: directed test-plan steps then random traffic, all checked against a register-level model
module tb_cp0_multitimer;
  localparam int NT = 2;
  localparam int DIV = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cp0_multitimer_if #(.NUM_TIMERS(NT)) bus();
  cp0_multitimer #(.NUM_TIMERS(NT), .COUNT_DIV(DIV)) dut(.clk(clk), .reset(reset), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  logic [31:0] m_count, m_status, m_epc, m_bva;
  logic [31:0] m_cmp [NT];
  logic [NT-1:0] m_flag;
  logic m_bd;
  logic [4:0] m_exc;
  logic [1:0] m_ipsw;
  logic [5:0] m_ext;
  int m_phase;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] m_ip();
    return {m_ext[5] | (|m_flag), m_ext[4:0], m_ipsw};
  endfunction
  function automatic logic [31:0] m_rd(logic [4:0] ra, logic [2:0] rsel);
    case (ra)
      5'd8: return m_bva;
      5'd9: return m_count;
      5'd11: return int'(rsel) < NT ? m_cmp[int'(rsel)] : 32'd0;
      5'd12: return m_status;
      5'd13: return {m_bd, |m_flag, 14'b0, m_ip(), 1'b0, m_exc, 2'b0};
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction
  task automatic model_edge();
    logic wr;
    if (reset) begin
      m_count = 0; m_status = 32'h0040_0000; m_epc = 0; m_bva = 0; m_flag = 0;
      m_bd = 0; m_exc = 0; m_ipsw = 0; m_ext = 0; m_phase = 0;
      for (int k = 0; k < NT; k++) m_cmp[k] = 0;
      return;
    end
    wr = bus.write_enable & ~bus.exception_enable & ~bus.eret_enable;
    if (wr && bus.wa == 9) begin
      m_count = bus.wd;
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase % DIV == 0) begin
        m_count++;
        for (int k = 0; k < NT; k++) if (m_count == m_cmp[k]) m_flag[k] = 1'b1;
      end
    end
    for (int k = 0; k < NT; k++)
      if (wr && bus.wa == 11 && int'(bus.wsel) == k) begin
        m_cmp[k] = bus.wd;
        m_flag[k] = 1'b0;
      end
    m_ext = bus.ext_int;
    if (bus.exception_enable) begin
      m_exc = bus.ecode;
      if (bus.ecode == 4 || bus.ecode == 5) m_bva = bus.addr;
      if (!m_status[1]) begin
        m_epc = bus.bd ? bus.pc - 4 : bus.pc;
        m_bd = bus.bd;
      end
      m_status[1] = 1'b1;
    end else if (bus.eret_enable) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      if (bus.wa == 12) m_status = (m_status & ~32'h0000_FF03) | (bus.wd & 32'h0000_FF03);
      if (bus.wa == 13) m_ipsw = bus.wd[9:8];
      if (bus.wa == 14) m_epc = bus.wd;
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("rd", bus.rd, m_rd(bus.ra, bus.rsel));
    check("epc", bus.epc, m_epc);
    check("timer_irq", 32'(bus.timer_irq), 32'(m_flag));
    check("interrupt_info", 32'(bus.interrupt_info),
          32'(m_ip() & m_status[15:8] & {8{m_status[0] & ~m_status[1]}}));
  endtask
  task automatic mtc0(logic [4:0] wa, logic [2:0] wsel, logic [31:0] wd);
    bus.write_enable = 1'b1; bus.wa = wa; bus.wsel = wsel; bus.wd = wd;
    step();
    bus.write_enable = 1'b0;
  endtask
  task automatic rdchk(string tag, logic [4:0] ra, logic [2:0] rsel, logic [31:0] exp);
    bus.ra = ra; bus.rsel = rsel;
    #1;
    check(tag, bus.rd, exp);
  endtask
  initial begin
    bus.ra = 0; bus.wa = 0; bus.rsel = 0; bus.wsel = 0; bus.write_enable = 0; bus.wd = 0;
    bus.exception_enable = 0; bus.ecode = 0; bus.pc = 0; bus.addr = 0; bus.bd = 0;
    bus.eret_enable = 0; bus.ext_int = 0;
    step();
    step();
    reset = 1'b0;
    rdchk("status_reset", 12, 0, 32'h0040_0000);
    rdchk("cause_reset", 13, 0, 0);
    check("epc_reset", bus.epc, 0);
    check("irq_reset", 32'(bus.timer_irq), 0);
    repeat (10) step();
    rdchk("count_idle", 9, 0, 5);
    mtc0(11, 1, 8);
    mtc0(12, 0, 32'h0000_8001);
    mtc0(9, 0, 5);
    repeat (5) step();
    check("irq_before_match", 32'(bus.timer_irq), 0);
    step();
    check("irq_match1", 32'(bus.timer_irq), 2);
    check("ii_match1", 32'(bus.interrupt_info), 32'h80);
    mtc0(11, 1, 8);
    check("irq_cleared", 32'(bus.timer_irq), 0);
    check("ii_cleared", 32'(bus.interrupt_info), 0);
    mtc0(9, 0, 32'hFFFF_FFFF);
    step();
    step();
    rdchk("count_wrap", 9, 0, 0);
    check("irq_wrap", 32'(bus.timer_irq), 1);
    mtc0(11, 0, 32'h100);
    bus.exception_enable = 1; bus.bd = 1; bus.pc = 32'hBFC0_0104; bus.ecode = 4; bus.addr = 1;
    step();
    bus.exception_enable = 0;
    check("epc_exc1", bus.epc, 32'hBFC0_0100);
    rdchk("bva_exc1", 8, 0, 1);
    rdchk("cause_exc1", 13, 0, 32'h8000_0010);
    rdchk("status_exc1", 12, 0, 32'h0040_8003);
    bus.exception_enable = 1; bus.bd = 0; bus.pc = 32'h200; bus.ecode = 0; bus.addr = 32'h55;
    step();
    bus.exception_enable = 0;
    check("epc_exc2", bus.epc, 32'hBFC0_0100);
    rdchk("cause_exc2", 13, 0, 32'h8000_0000);
    rdchk("bva_exc2", 8, 0, 1);
    bus.eret_enable = 1;
    step();
    bus.eret_enable = 0;
    rdchk("status_eret", 12, 0, 32'h0040_8001);
    bus.exception_enable = 1; bus.pc = 32'h300; bus.ecode = 8;
    bus.write_enable = 1; bus.wa = 14; bus.wd = 32'h1234;
    step();
    bus.exception_enable = 0; bus.write_enable = 0;
    check("epc_exc_vs_mtc0", bus.epc, 32'h300);
    bus.eret_enable = 1;
    step();
    bus.eret_enable = 0;
    mtc0(11, 0, 101);
    mtc0(9, 0, 100);
    step();
    mtc0(11, 0, 101);
    rdchk("count_at_cmp", 9, 0, 101);
    check("irq_write_wins", 32'(bus.timer_irq), 0);
    mtc0(9, 0, 101);
    check("irq_count_write_eq", 32'(bus.timer_irq), 0);
    step();
    check("irq_count_write_eq2", 32'(bus.timer_irq), 0);
    mtc0(12, 0, 32'h0000_0401);
    bus.ext_int = 6'b000001;
    #1;
    check("ext_latency", 32'(bus.interrupt_info), 0);
    step();
    check("ext_ii", 32'(bus.interrupt_info), 32'h04);
    mtc0(12, 0, 32'h0000_0403);
    check("ext_ii_exl", 32'(bus.interrupt_info), 0);
    bus.ext_int = 0;
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 800; i++) begin
      int r;
      int wl[7];
      wl = '{8, 9, 11, 12, 13, 14, 3};
      r = $urandom_range(0, 199);
      reset = (r == 0);
      bus.exception_enable = (r >= 1 && r < 9);
      bus.eret_enable = (r >= 9 && r < 17);
      bus.write_enable = ($urandom_range(0, 2) == 0);
      bus.wa = 5'(wl[$urandom_range(0, 6)]);
      bus.wsel = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: bus.wd = $urandom;
        1: bus.wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: bus.wd = 32'($urandom_range(0, 40)) | ($urandom_range(0, 1) ? 32'h0000_FC01 : 32'h0);
      endcase
      bus.ra = 5'(wl[$urandom_range(0, 6)]);
      bus.rsel = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) bus.ext_int = 6'($urandom);
      bus.pc = $urandom & 32'hFFFF_FFFC;
      bus.addr = $urandom;
      bus.bd = 1'($urandom);
      bus.ecode = 5'($urandom_range(0, 7));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cp0_multitimer.md
# cp0_multitimer

Parametrised successor to the single-timer coprocessor-0 block: the same CP0 register file (BadVAddr, Count, Status, Cause, EPC) with NUM_TIMERS Compare channels selected by the MTC0/MFC0 sel field. It adds a programmable Count prescaler, sticky per-channel timer-interrupt flags, and a registered external-interrupt input stage. It sits beside the writeback/exception stage of the pipeline. It produces the masked pending-interrupt vector and the EPC for ERET.

## Interface
Parameters:
- NUM_TIMERS, 1: number of Compare channels, 1..8; channel k is CP0 reg 11 with sel = k.
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles; a power of two, at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ra, wa  in  5  read/write register index.
- rsel, wsel  in  3  read/write select field.
- write_enable  in  1  MTC0 strobe.
- wd  in  32  MTC0 data.
- rd  out  32  MFC0 data, combinational from current registered state.
- interrupt_info  out  8  pending AND enabled interrupt lines, IP[7:0].
- exception_enable  in  1  exception commit.
- ecode  in  5  exception code.
- pc, addr  in  32  faulting PC and faulting data address.
- bd  in  1  faulting instruction is in a delay slot.
- eret_enable  in  1  ERET commit.
- epc  out  32  current EPC.
- ext_int  in  6  hardware interrupt lines, active-high.
- timer_irq  out  NUM_TIMERS  per-channel sticky timer flag.

## Operation
- Register map:
  - 8 BadVAddr is read-only.
  - 9 Count is read/write.
  - 11/sel k Compare[k] is read/write.
  - 12 Status: writable IM[15:8], EXL[1] and IE[0]; other bits read as their reset value.
  - 13 Cause: writable IP[9:8] only; BD[31], TI[30], IP[15:10] and ExcCode[6:2] are hardware-owned.
  - 14 EPC is read/write.
  - Unmapped index, or sel ≥ NUM_TIMERS, reads 0 and ignores writes.
- Update priority each cycle: reset > exception > eret > MTC0. A lower-priority event in the same cycle is dropped. Count and prescaler advance independently of this chain, except that an MTC0 to Count overrides the advance.
- Prescaler:
  - log2(COUNT_DIV)-bit counter; a tick occurs when it wraps to 0.
  - On a tick, Count = Count + 1, modulo 2^32; FFFF_FFFF wraps to 0.
  - MTC0 Count loads wd and clears the prescaler.
  - With COUNT_DIV = 1, every cycle is a tick.
- Timer match:
  - On a tick, if the new Count == Compare[k], set flag[k].
  - MTC0 to Compare[k] clears flag[k] and loads Compare[k].
  - If that write lands in the same cycle as a match on k, the clear wins.
  - A Count write that equals Compare does not set a flag.
- Cause:
  - Cause.TI = OR of all flags.
  - Cause.IP7 = ext_int_q[5] OR TI.
  - Cause.IP[14:10] = ext_int_q[4:0].
  - ext_int_q is ext_int registered once every cycle.
- Exception:
  - Cause.ExcCode = ecode.
  - If ecode is AdEL (4) or AdES (5), BadVAddr = addr.
  - If EXL = 0: EPC = bd ? pc − 4 : pc, and Cause.BD = bd.
  - If EXL = 1: EPC and BD are unchanged.
  - EXL is then set to 1.
- ERET: EXL = 0; nothing else changes.
- interrupt_info = Cause.IP[15:8] & Status.IM[15:8] & {8{IE & ~EXL}}.
- timer_irq = flag vector.

## Timing
- Reset values:
  - All registers, flags, prescaler and ext_int_q are 0, except Status = 0x0040_0000 (BEV = 1, IE = 0, EXL = 0).
  - So interrupt_info = 0, epc = 0, timer_irq = 0, and rd of any register except Status reads 0.
  - Reset mid-operation takes effect on the next edge and discards all same-cycle events.
- MTC0 and events are visible on rd/epc/interrupt_info the cycle after the strobe edge. There is no same-cycle write-to-read bypass.
- Timer latency:
  - The tick edge that makes Count == Compare[k] sets flag[k] at that edge.
  - timer_irq[k] and Cause.TI are high in the following cycle.
  - interrupt_info[7] is high the same cycle if enabled.
- External interrupt: ext_int to interrupt_info is 1 cycle, through ext_int_q.
- The first tick after reset occurs COUNT_DIV cycles after reset deasserts.

## Test plan
- Reset, then idle with COUNT_DIV = 2 -> Status reads 0x0040_0000; Count reads 5 after 10 cycles.
- NUM_TIMERS = 2; Compare[1] = 8, Status = 0x0000_8001, Count = 5 -> timer_irq = 2'b10 and interrupt_info[7] = 1 once Count reaches 8. MTC0 Compare[1] clears both next cycle; Compare[0] = 0 never fires.
- Count = 0xFFFF_FFFF, Compare[0] = 0 -> the tick wraps Count to 0 and sets flag[0].
- Exception with bd = 1, pc = 0xBFC0_0104, ecode = 4, addr = 0x1 -> EPC = 0xBFC0_0100, BadVAddr = 0x1, BD = 1, EXL = 1. A second exception with pc = 0x200 leaves EPC unchanged; ERET then clears EXL.
- Same-cycle exception + MTC0 EPC = 0x1234 -> the exception value is kept. Same-cycle Compare write + match -> flag stays 0.
- ext_int = 6'b000001 with IM2 = 1, IE = 1 -> interrupt_info = 0x04 one cycle later; with EXL = 1 -> 0x00.
